// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, instruction
// field positions and fetch FSM state encodings.
package mips_pkg;

   localparam logic [5:0] OP_ADD      = 6'd0;
   localparam logic [5:0] OP_SUB      = 6'd1;
   localparam logic [5:0] OP_MUL      = 6'd2;
   localparam logic [5:0] OP_AND      = 6'd3;
   localparam logic [5:0] OP_OR       = 6'd4;
   localparam logic [5:0] OP_ADDI     = 6'd5;
   localparam logic [5:0] OP_LBD      = 6'd10;
   localparam logic [5:0] OP_LDW      = 6'd11;
   localparam logic [5:0] OP_STB      = 6'd12;
   localparam logic [5:0] OP_STW      = 6'd13;
   localparam logic [5:0] OP_MOV      = 6'd14;
   localparam logic [5:0] OP_BEQ      = 6'd20;
   localparam logic [5:0] OP_JUMP     = 6'd21;
   localparam logic [5:0] OP_TLBWRITE = 6'd30;
   localparam logic [5:0] OP_IRET     = 6'd31;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_ADDI,
         OP_LBD, OP_LDW, OP_STB, OP_STW, OP_MOV,
         OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET: is_legal_op = 1'b1;
         default:                               is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: instruction-memory req/ack, execute redirect and
// the valid/ready opcode stream toward decode.
interface instr_fetch_if #(parameter int ADDR_W = 32);

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;

   logic              id_valid;
   logic              id_ready;
   logic [5:0]        id_op;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_rd;
   logic [15:0]       id_imm;
   logic [ADDR_W-1:0] id_pc;
   logic              id_illegal;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect, redirect_pc,
      output id_valid,
      input  id_ready,
      output id_op, id_rs, id_rt, id_rd, id_imm, id_pc, id_illegal
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect, redirect_pc,
      input  id_valid,
      output id_ready,
      input  id_op, id_rs, id_rt, id_rd, id_imm, id_pc, id_illegal
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, word} entries with a registered head
// so decode sees stable fields straight from flops.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_next;
   logic             do_push;
   logic             do_pop;

   assign rd_next = rd_ptr + 1'b1;
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_next;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // Head follows whichever entry will be at the front after this edge.
         if (do_push && ((count == '0) || (do_pop && (count == CNT_W'(1))))) begin
            head <= push_data;
         end else if (do_pop && (count > CNT_W'(1))) begin
            head <= mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, single-outstanding imem request, redirect
// handling and a small buffer presenting split fields to decode.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | one cycle after reset, no request
//   ST_FETCH | request at pc whenever the buffer has room
//   ST_DRAIN | redirect hit an un-acked request; hold it, discard its data
module instr_fetch
   import mips_pkg::*;
#(
   parameter int              ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   instr_fetch_if.master  bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] drain_addr;
   logic              req_pend;
   logic              req;
   logic              push;
   logic              pop;
   logic              flush;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W+31:0] head;
   logic [31:0]       instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         req_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         req_pend <= req && !bus.imem_ack;
      end
   end

   // Outside DRAIN this tracks pc, so on entry it holds the address still owed an ack.
   always_ff @(posedge clk) begin
      if (state != ST_DRAIN) drain_addr <= pc;
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      req       = 1'b0;
      push      = 1'b0;
      flush     = 1'b0;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_FETCH;
            if (bus.redirect) begin
               pc_nxt = bus.redirect_pc;
               flush  = 1'b1;
            end
         end
         ST_FETCH: begin
            if (bus.redirect) begin
               flush  = 1'b1;
               pc_nxt = bus.redirect_pc;
               req    = req_pend;
               if (req_pend && !bus.imem_ack) state_nxt = ST_DRAIN;
            end else begin
               req = (cnt < CNT_W'(FIFO_DEPTH));
               if (req && bus.imem_ack) begin
                  push   = 1'b1;
                  pc_nxt = pc + ADDR_W'(4);
               end
            end
         end
         ST_DRAIN: begin
            req = 1'b1;
            if (bus.redirect) begin
               pc_nxt = bus.redirect_pc;
               flush  = 1'b1;
            end
            if (bus.imem_ack) state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign pop = bus.id_valid && bus.id_ready && !bus.redirect;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + 32)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .push_data ({pc, bus.imem_rdata}),
      .head      (head),
      .count     (cnt)
   );

   assign instr          = head[31:0];
   assign bus.imem_req   = req;
   assign bus.imem_addr  = (state == ST_DRAIN) ? drain_addr : pc;
   assign bus.id_valid   = (cnt != '0);
   assign bus.id_pc      = head[ADDR_W+31:32];
   assign bus.id_op      = instr[OP_MSB:OP_LSB];
   assign bus.id_rs      = instr[RS_MSB:RS_LSB];
   assign bus.id_rt      = instr[RT_MSB:RT_LSB];
   assign bus.id_rd      = instr[RD_MSB:RD_LSB];
   assign bus.id_imm     = instr[IMM_MSB:IMM_LSB];
   assign bus.id_illegal = bus.id_valid && !is_legal_op(bus.id_op);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed corner cases
// and randomized traffic against a stream-level reference model.
module tb_instr_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_w;

   instr_fetch_if #(.ADDR_W(32)) bus_a ();
   instr_fetch_if #(.ADDR_W(32)) bus_b ();

   instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut_a (
      .clk (clk), .rst (rst_a), .bus (bus_a));

   instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_b (
      .clk (clk), .rst (rst_w), .bus (bus_b));

   typedef struct {
      logic [31:0] word;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic        ill;
   } vec_t;

   vec_t vec [10];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;
   int          n_pops;
   int          n_acks;
   bit          tbl_mode;
   bit          prev_pend;
   logic [31:0] prev_addr;
   bit          prev_redir;
   bit          prev_rst;

   function automatic logic [31:0] hash_word(input logic [31:0] a);
      logic [5:0] op;
      op = a[7:2] ^ a[13:8] ^ a[19:14];
      return {op, a[27:2] ^ 26'h2A5_5A5A};
   endfunction

   function automatic bit op_legal(input logic [5:0] op);
      return op inside {[6'd0:6'd5], [6'd10:6'd14], 6'd20, 6'd21, 6'd30, 6'd31};
   endfunction

   function automatic logic [31:0] mem_a(input logic [31:0] a);
      if (tbl_mode && a < 32'd40) return vec[a[5:2]].word;
      return hash_word(a);
   endfunction

   function automatic logic [31:0] mem_b(input logic [31:0] a);
      if (a == 32'hFFFF_FFFC) return 32'h1800_0000;
      if (a == 32'h0000_0000) return 32'h7C00_0000;
      return hash_word(a);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycle_a(input bit r, input bit redir, input logic [31:0] rpc,
                          input bit rdy, input int amode);
      bit          a;
      logic [31:0] w;
      @(negedge clk);
      rst_a              = r;
      bus_a.redirect     = redir;
      bus_a.redirect_pc  = rpc;
      bus_a.id_ready     = rdy;
      #1;
      case (amode)
         0:       a = 1'b0;
         1:       a = bus_a.imem_req;
         2:       a = bus_a.imem_req && ($urandom_range(99) < 50);
         default: a = 1'b1;
      endcase
      bus_a.imem_ack   = a;
      bus_a.imem_rdata = mem_a(bus_a.imem_addr);
      #1;
      if (prev_rst) chk("post_rst_req_valid", {bus_a.imem_req, bus_a.id_valid}, 2'b00);
      else if (prev_redir) chk("flush_valid", bus_a.id_valid, 1'b0);
      if (prev_pend) chk("req_addr_held", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, prev_addr});
      if (!r && !redir && bus_a.id_valid && rdy) begin
         w = mem_a(exp_pc);
         chk("pop_pc", bus_a.id_pc, exp_pc);
         chk("pop_fields", {bus_a.id_op, bus_a.id_rs, bus_a.id_rt, bus_a.id_rd, bus_a.id_imm},
             {w[31:26], w[25:21], w[20:16], w[15:11], w[15:0]});
         chk("pop_illegal", bus_a.id_illegal, !op_legal(w[31:26]));
         if (tbl_mode && exp_pc < 32'd40)
            chk("vec_fields",
                {bus_a.id_op, bus_a.id_rs, bus_a.id_rt, bus_a.id_rd, bus_a.id_imm, bus_a.id_illegal},
                {vec[exp_pc[5:2]].op, vec[exp_pc[5:2]].rs, vec[exp_pc[5:2]].rt,
                 vec[exp_pc[5:2]].rd, vec[exp_pc[5:2]].imm, vec[exp_pc[5:2]].ill});
         exp_pc = exp_pc + 32'd4;
         n_pops++;
      end
      if (a && bus_a.imem_req && !r) n_acks++;
      if (r)          exp_pc = 32'h0;
      else if (redir) exp_pc = rpc;
      prev_pend  = bus_a.imem_req && !a && !r;
      prev_addr  = bus_a.imem_addr;
      prev_redir = redir;
      prev_rst   = r;
   endtask

   task automatic reset_a();
      cycle_a(1, 0, 32'h0, 0, 0);
      cycle_a(1, 0, 32'h0, 0, 0);
      n_pops = 0;
      n_acks = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] old_addr;
      logic [31:0] fetch_q [$];
      logic [32:0] pop_q [$];
      bit          seen;

      vec[0] = '{32'h0022_1800, 6'd0,  5'd1, 5'd2, 5'd3,  16'h1800, 1'b0};
      vec[1] = '{32'h1800_0000, 6'd6,  5'd0, 5'd0, 5'd0,  16'h0000, 1'b1};
      vec[2] = '{32'hFC00_0000, 6'd63, 5'd0, 5'd0, 5'd0,  16'h0000, 1'b1};
      vec[3] = '{32'h7C00_0000, 6'd31, 5'd0, 5'd0, 5'd0,  16'h0000, 1'b0};
      vec[4] = '{32'h14A5_FFFF, 6'd5,  5'd5, 5'd5, 5'd31, 16'hFFFF, 1'b0};
      vec[5] = '{32'h2800_0000, 6'd10, 5'd0, 5'd0, 5'd0,  16'h0000, 1'b0};
      vec[6] = '{32'h3C00_0000, 6'd15, 5'd0, 5'd0, 5'd0,  16'h0000, 1'b1};
      vec[7] = '{32'h5000_0000, 6'd20, 5'd0, 5'd0, 5'd0,  16'h0000, 1'b0};
      vec[8] = '{32'h2400_0000, 6'd9,  5'd0, 5'd0, 5'd0,  16'h0000, 1'b1};
      vec[9] = '{32'h5800_0000, 6'd22, 5'd0, 5'd0, 5'd0,  16'h0000, 1'b1};

      rst_a = 1'b1;  rst_w = 1'b1;
      bus_a.redirect = 1'b0; bus_a.redirect_pc = '0; bus_a.id_ready = 1'b0;
      bus_a.imem_ack = 1'b0; bus_a.imem_rdata = '0;
      bus_b.redirect = 1'b0; bus_b.redirect_pc = '0; bus_b.id_ready = 1'b0;
      bus_b.imem_ack = 1'b0; bus_b.imem_rdata = '0;
      exp_pc = 32'h0; prev_pend = 0; prev_redir = 0; prev_rst = 0;
      tbl_mode = 1'b0;

      // Reset state
      reset_a();
      cycle_a(1, 0, 32'h0, 0, 0);
      chk("reset_outputs",
          {bus_a.imem_req, bus_a.id_valid, bus_a.id_illegal, bus_a.id_op, bus_a.id_rs,
           bus_a.id_rt, bus_a.id_rd, bus_a.id_imm, bus_a.id_pc}, '0);

      // Vector table with back-to-back acks and decode always ready
      tbl_mode = 1'b1;
      for (int i = 0; i < 40 && n_pops < 10; i++) begin
         cycle_a(0, 0, 32'h0, 1, 1);
         if (i == 1) chk("first_req_addr", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 32'h0});
         if (i == 2) chk("first_latency_valid", bus_a.id_valid, 1'b1);
      end
      chk("tbl_all_delivered", n_pops >= 10, 1'b1);
      reset_a();
      tbl_mode = 1'b0;

      // Backpressure: buffer fills to two words, request stops
      for (int i = 0; i < 12; i++) cycle_a(0, 0, 32'h0, 0, 1);
      chk("bp_acks", n_acks, 2);
      chk("bp_req_off", bus_a.imem_req, 1'b0);
      chk("bp_head", {bus_a.id_valid, bus_a.id_pc}, {1'b1, 32'h0});
      for (int i = 0; i < 20; i++) cycle_a(0, 0, 32'h0, 1, 1);
      chk("bp_release_progress", n_pops >= 15, 1'b1);
      reset_a();

      // Redirect while a request waits unacked: DRAIN on the old address
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle_a(0, 0, 32'h0, 1, 0);
         seen = bus_a.imem_req;
      end
      chk("drain_req_seen", seen, 1'b1);
      old_addr = bus_a.imem_addr;
      cycle_a(0, 1, 32'h0000_0100, 1, 0);
      chk("drain_redirect_cycle", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, old_addr});
      for (int i = 0; i < 3; i++) begin
         cycle_a(0, 0, 32'h0, 1, 0);
         chk("drain_hold", {bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid}, {1'b1, old_addr, 1'b0});
      end
      cycle_a(0, 0, 32'h0, 1, 1);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle_a(0, 0, 32'h0, 1, 1);
         seen = bus_a.id_valid;
      end
      chk("drain_first_pc", {seen, bus_a.id_pc}, {1'b1, 32'h0000_0100});
      reset_a();

      // Redirect coinciding with ack and pop
      for (int i = 0; i < 6; i++) cycle_a(0, 0, 32'h0, 1, 1);
      cycle_a(0, 0, 32'h0, 0, 0);
      cycle_a(0, 1, 32'h0000_0200, 1, 1);
      chk("t4_pre_valid_req", {bus_a.id_valid, bus_a.imem_req, bus_a.imem_ack}, 3'b111);
      cycle_a(0, 0, 32'h0, 1, 1);
      chk("t4_empty", bus_a.id_valid, 1'b0);
      n_pops = 0;
      for (int i = 0; i < 10; i++) cycle_a(0, 0, 32'h0, 1, 1);
      chk("t4_resume", n_pops >= 5, 1'b1);
      reset_a();

      // Reset mid-request with a stray ack right after
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle_a(0, 0, 32'h0, 1, 0);
         seen = bus_a.imem_req;
      end
      chk("rst_req_seen", seen, 1'b1);
      cycle_a(1, 0, 32'h0, 1, 0);
      cycle_a(0, 0, 32'h0, 1, 3);
      chk("rst_after", {bus_a.imem_req, bus_a.id_valid}, 2'b00);
      cycle_a(0, 0, 32'h0, 1, 1);
      chk("rst_refetch", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 32'h0});
      cycle_a(0, 0, 32'h0, 1, 1);
      chk("rst_first_pc", {bus_a.id_valid, bus_a.id_pc}, {1'b1, 32'h0});

      // Randomized traffic against the stream model
      n_pops = 0;
      for (int i = 0; i < 3000; i++) begin
         bit          r, rd, rdy;
         logic [31:0] rpc;
         r   = ($urandom_range(399) == 0);
         rd  = ($urandom_range(24) == 0);
         rdy = ($urandom_range(99) < 70);
         rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
         cycle_a(r, rd, rpc, rdy, 2);
      end
      chk("rand_progress", n_pops > 300, 1'b1);

      // PC wrap and illegal flag on the second instance
      for (int i = 0; i < 2; i++) @(negedge clk);
      rst_w = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus_b.id_ready = 1'b1;
         #1;
         bus_b.imem_ack   = bus_b.imem_req;
         bus_b.imem_rdata = mem_b(bus_b.imem_addr);
         #1;
         if (bus_b.imem_req) fetch_q.push_back(bus_b.imem_addr);
         if (bus_b.id_valid) pop_q.push_back({bus_b.id_illegal, bus_b.id_pc});
      end
      chk("wrap_counts", {fetch_q.size() >= 2, pop_q.size() >= 2}, 2'b11);
      if (fetch_q.size() >= 2 && pop_q.size() >= 2) begin
         chk("wrap_second_fetch", fetch_q[1], 32'h0000_0000);
         chk("wrap_pop0_illegal", pop_q[0], {1'b1, 32'hFFFF_FFFC});
         chk("wrap_pop1_legal", pop_q[1], {1'b0, 32'h0000_0000});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
